// File: rtl/sy_tick_gen.sv
// Programmable enable-tick generator: one-cycle ticks every div_q+1 clocks,
// continuous or as a counted burst, with a handshaked divider update.
module sy_tick_gen #(
  parameter int W           = 8,
  parameter int CW          = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          mode_i,
  input  logic [CW-1:0] burst_len_i,
  input  logic [W-1:0]  div_in_i,
  input  logic          div_valid_i,
  output logic          div_ready_o,
  output logic          enable_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] pulse_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  div_q, div_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  pre_q, pre_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] cnt_inc;
  logic          xfer;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_q    <= W'(DEFAULT_DIV);
      shadow_q <= '0;
      pend_q   <= 1'b0;
      pre_q    <= '0;
      mode_q   <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pre_q    <= pre_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pre_d    = pre_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    // Shadow is only writable while empty, so a transfer never races an apply.
    xfer     = div_valid_i && !pend_q;

    if (xfer) begin
      shadow_d = div_in_i;
      pend_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
        if (start_i && !stop_i) begin
          cnt_d  = '0;
          mode_d = mode_i;
          len_d  = burst_len_i;
          pre_d  = div_q;
          if (mode_i && (burst_len_i == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (pre_q != '0) begin
          pre_d = pre_q - 1'b1;
        end else begin
          enable_d = 1'b1;
          cnt_d    = cnt_inc;
          // A pending divider takes effect only at a reload, so the period
          // in progress always finishes with the old value.
          if (pend_q) begin
            div_d  = shadow_q;
            pre_d  = shadow_q;
            pend_d = 1'b0;
          end else begin
            pre_d = div_q;
          end
          if (mode_q && (cnt_inc == len_q)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
        state_d = IDLE;
        if (!stop_i) begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == DONE);
  end

  assign div_ready_o = !pend_q;
  assign enable_o    = enable_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_cnt_o = cnt_q;

endmodule

// File: doc/sy_tick_gen.md
# sy_tick_gen

Programmable enable-tick generator that sits directly upstream of the synchronous down counter and drives its `enable` input. It emits one-cycle `enable` pulses at a programmable period, either continuously or as a fixed-length burst. A valid/ready handshake updates the period safely while running. Burst completion is reported with a `done` pulse, so a controller can step the down counter by an exact count.

## Interface
- `W`, 8: divider width; period = div_q + 1 clock cycles
- `CW`, 8: burst length / pulse counter width
- `DEFAULT_DIV`, 4: divider value loaded at reset (period 5)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin operation; honoured only in IDLE
- `stop`  in  1  abort to IDLE; priority over every other input
- `mode`  in  1  0 = continuous, 1 = burst; sampled with `start`
- `burst_len`  in  CW  pulses to emit in burst mode; sampled with `start`
- `div_in`  in  W  new divider value
- `div_valid`  in  1  `div_in` offered
- `div_ready`  out  1  divider shadow register free
- `enable`  out  1  registered one-cycle tick to the down counter
- `busy`  out  1  registered; high in RUN and DONE
- `done`  out  1  registered one-cycle pulse at end of burst
- `pulse_cnt`  out  CW  ticks emitted since last `start`

## Operation
- Reset values:
  - state = IDLE, div_q = DEFAULT_DIV, pre = 0, pend = 0
  - `div_ready` = 1; `enable`, `busy`, `done` = 0; `pulse_cnt` = 0
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1, `stop`=0, and (`mode`=0 or `burst_len`≠0):
    - go to RUN; pre ← div_q, `pulse_cnt` ← 0
    - latch `mode` and `burst_len` (len_q)
  - IDLE, `start`=1, `mode`=1, `burst_len`=0: go to DONE with no tick; `pulse_cnt` ← 0.
  - RUN, pre≠0: pre ← pre−1.
  - RUN, pre=0:
    - `enable` ← 1, `pulse_cnt` ← `pulse_cnt`+1 (wraps mod 2^CW)
    - pre ← new div_q (pending value applied at this reload)
    - in burst mode, when this is tick number len_q, go to DONE
  - DONE: `done` ← 1, go to IDLE.
  - `stop`=1 in RUN or DONE: go to IDLE next edge. No `enable` and no `done` are produced on that edge.
  - `start` while not IDLE: ignored. `start`+`stop` together in IDLE: stays in IDLE.
- Divider handshake:
  - Transfer occurs when `div_valid` & `div_ready` on an edge: shadow ← `div_in`, pend ← 1, so `div_ready` = !pend.
  - In IDLE or DONE, the pending value moves to div_q on the next edge.
  - In RUN, it moves at the next reload (pre=0 edge). The current period always completes with the old value.
  - pend clears on the apply edge, and `div_ready` is high again after it.
- `pulse_cnt` holds its value in IDLE until the next accepted `start`.
- div_q = 0 is legal: one tick every cycle.

## Timing
- Edge 0 is the edge that samples an accepted `start`. `busy` is high after edge 0.
- The first `enable` is high after edge div_q+1. Subsequent ticks follow every div_q+1 edges.
- Burst: the last `enable` is high after edge E; `done` and `busy`=0 follow after edge E+1.
- `enable`, `done` and `busy` are registered, with no combinational path from inputs.
- Asynchronous reset mid-operation:
  - all outputs clear immediately
  - the pending divider is discarded
  - div_q returns to DEFAULT_DIV

## Test plan
- Reset, then `start` with `mode`=0 and div=4 → `enable` after edges 5, 10, 15; `pulse_cnt` = 1, 2, 3; `busy`=1 throughout.
- div_in=2 loaded in IDLE, then burst with `burst_len`=3 → `enable` after edges 3, 6, 9; `done` and `busy`=0 after edge 10; `pulse_cnt` holds 3.
- Continuous run with div=4; `div_in`=1 with `div_valid` at edge 7 → `div_ready`=0 after edge 7; ticks at edges 5 and 10, then 12, 14, 16; `div_ready`=1 after edge 10.
- Continuous run with div=4; `stop` at edge 10 → no tick at edge 10, `busy`=0 after edge 10, `done` stays 0; `start`+`stop` together in IDLE → stays in IDLE.
- `mode`=1, `burst_len`=0 → no `enable` ever; `busy`=1 after edge 0 only; `done` after edge 1.
- Asynchronous reset low mid-burst, between edges, with a divider pending → `enable`, `busy`, `done` and `pulse_cnt` go to 0 at once; `div_ready`=1; next `start` runs with period 5.
